// File: rtl/axis_bram_adapter_pkg.sv
// Shared types and helpers for the AXI-Stream <-> BRAM line adapter.
package axis_bram_adapter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_FILL,
        WR_COMMIT,
        RD_ISSUE,
        RD_WAIT,
        RD_DRAIN,
        DONE
    } state_e;

    // Bit offset of word idx inside a packed line.
    function automatic int unsigned word_sel(input int unsigned idx, input int unsigned word_w);
        return idx * word_w;
    endfunction

    // Number of lines from start to bound inclusive, with addresses wrapping at 2^addr_w.
    function automatic logic [31:0] line_count(input logic [31:0] start_idx,
                                               input logic [31:0] bound_idx,
                                               input int unsigned addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
        return ((bound_idx - start_idx) & mask) + 32'd1;
    endfunction

endpackage

// File: rtl/axis_bram_adapter_v2_0_linebuf.sv
// One BRAM line held as WORDS stream words: indexed word write/read, zero-clear, parallel load.
module axis_bram_adapter_v2_0_linebuf
    import axis_bram_adapter_pkg::*;
#(
    parameter  int WORD_W = 16,
    parameter  int WORDS  = 36,
    localparam int IDX_W  = $clog2(WORDS),
    localparam int LINE_W = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // NOTE: every always_comb target gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        line_d = line_q;
        if (clr)     line_d = '0;
        if (load_en) line_d = load_data;
        if (wr_en)   line_d[word_sel(32'(wr_idx), WORD_W) +: WORD_W] = wr_data;
    end

    // NOTE: this storage is reset on purpose so a half-filled line never outlives a reset; plain RAM arrays normally get no reset.
    always_ff @(posedge clk) begin
        if (!rstn) line_q <= '0;
        else       line_q <= line_d;
    end

    assign rd_data = line_q[word_sel(32'(rd_idx), WORD_W) +: WORD_W];
    assign line    = line_q;

endmodule

// File: rtl/axis_bram_adapter_v2_0_core.sv
// AXI-Stream <-> wide BRAM line adapter: packs stream words into lines on write, unpacks lines onto a stream on read.
module axis_bram_adapter_v2_0_core
    import axis_bram_adapter_pkg::*;
#(
    parameter int WORD_W         = 16,
    parameter int WORDS_PER_LINE = 36,
    parameter int ADDR_W         = 12,
    parameter int RD_LATENCY     = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic                             rw,
    input  logic [ADDR_W-1:0]                start_index,
    input  logic [ADDR_W-1:0]                bound_index,
    output logic                             busy,
    output logic                             done,
    output logic                             early_last,
    input  logic [WORD_W-1:0]                s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [WORD_W-1:0]                m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             bram_en,
    output logic                             bram_we,
    output logic [ADDR_W-1:0]                bram_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0] bram_wdata,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] bram_rdata
);

    localparam int IDX_W   = $clog2(WORDS_PER_LINE);
    localparam int CNT_MAX = (WORDS_PER_LINE > RD_LATENCY) ? WORDS_PER_LINE : RD_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int LINE_W  = WORD_W * WORDS_PER_LINE;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RD_LATENCY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic                tlast_seen_q, tlast_seen_d;
    logic                early_last_q, early_last_d;

    logic                buf_clr, buf_wr, buf_load;
    logic [WORD_W-1:0]   buf_word;
    logic [LINE_W-1:0]   buf_line;

    axis_bram_adapter_v2_0_linebuf #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS_PER_LINE)
    ) u_linebuf (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (buf_clr),
        .wr_en     (buf_wr),
        .wr_idx    (cnt_q[IDX_W-1:0]),
        .wr_data   (s_axis_tdata),
        .load_en   (buf_load),
        .load_data (bram_rdata),
        .rd_idx    (cnt_q[IDX_W-1:0]),
        .rd_data   (buf_word),
        .line      (buf_line)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        tlast_seen_d  = tlast_seen_q;
        early_last_d  = early_last_q;
        buf_clr       = 1'b0;
        buf_wr        = 1'b0;
        buf_load      = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        bram_en       = 1'b0;
        bram_we       = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = start_index;
                    // rem counts lines still to go after the current one.
                    rem_d        = ADDR_W'(line_count(32'(start_index), 32'(bound_index), ADDR_W) - 32'd1);
                    cnt_d        = '0;
                    tlast_seen_d = 1'b0;
                    early_last_d = 1'b0;
                    buf_clr      = 1'b1;
                    state_d      = rw ? WR_FILL : RD_ISSUE;
                end
            end
            WR_FILL: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    buf_wr = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (s_axis_tlast) tlast_seen_d = 1'b1;
                    if (cnt_q == LAST_WORD || s_axis_tlast) state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                bram_en = 1'b1;
                bram_we = 1'b1;
                cnt_d   = '0;
                buf_clr = 1'b1;
                if (rem_q == '0 || tlast_seen_q) begin
                    early_last_d = (rem_q != '0);
                    state_d      = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = WR_FILL;
                end
            end
            RD_ISSUE: begin
                bram_en = 1'b1;
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    buf_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = RD_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_DRAIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (cnt_q == LAST_WORD) && (rem_q == '0);
                if (m_axis_tready) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d = '0;
                        if (rem_q == '0) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            rem_d   = rem_q - 1'b1;
                            state_d = RD_ISSUE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            tlast_seen_q <= 1'b0;
            early_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            tlast_seen_q <= tlast_seen_d;
            early_last_q <= early_last_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign early_last   = early_last_q;
    assign bram_addr    = addr_q;
    assign bram_wdata   = (state_q == WR_COMMIT) ? buf_line : '0;
    assign m_axis_tdata = m_axis_tvalid ? buf_word : '0;

endmodule

// File: tb/tb_axis_bram_adapter_v2_0_core.sv
// Scoreboard bench for axis_bram_adapter_v2_0_core with a 2-cycle-latency BRAM model.
module tb_axis_bram_adapter_v2_0_core;

    localparam int WORD_W = 16;
    localparam int WPL    = 4;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;
    localparam int LINE_W = WORD_W * WPL;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              rw = 1'b0;
    logic [ADDR_W-1:0] start_index = '0;
    logic [ADDR_W-1:0] bound_index = '0;
    logic              busy, done, early_last;
    logic [WORD_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic [WORD_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              bram_en, bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [LINE_W-1:0] bram_wdata;
    logic [LINE_W-1:0] bram_rdata;

    axis_bram_adapter_v2_0_core #(
        .WORD_W         (WORD_W),
        .WORDS_PER_LINE (WPL),
        .ADDR_W         (ADDR_W),
        .RD_LATENCY     (RD_LAT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .rw            (rw),
        .start_index   (start_index),
        .bound_index   (bound_index),
        .busy          (busy),
        .done          (done),
        .early_last    (early_last),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data valid exactly RD_LAT cycles after a read enable, junk otherwise.
    logic [LINE_W-1:0] mem [16];
    logic              rv0 = 1'b0, rv1 = 1'b0;
    logic [ADDR_W-1:0] ra0 = '0, ra1 = '0;
    always @(posedge clk) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        rv0 <= bram_en && !bram_we;
        ra0 <= bram_addr;
        rv1 <= rv0;
        ra1 <= ra0;
    end
    assign bram_rdata = rv1 ? mem[ra1] : {4{16'hBAD0}};

    logic [ADDR_W-1:0] exp_wa [$];
    logic [LINE_W-1:0] exp_wd [$];
    logic [WORD_W-1:0] exp_rd [$];
    logic              exp_rl [$];
    int                rd_cyc [$];
    int                last_we_cyc = 0;
    logic [WORD_W-1:0] sw_data [$];
    logic              sw_last [$];
    logic [3:0]        pat = 4'b1001;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes BRAM or completes a stream beat.
    logic              prev_stall = 1'b0;
    logic              prev_we = 1'b0;
    logic [WORD_W-1:0] prev_data = '0;
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            prev_stall = 1'b0;
            prev_we    = 1'b0;
        end else begin
            if (bram_we) begin
                check("we_single_cycle", prev_we, 0);
                if (exp_wa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", bram_addr, bram_wdata);
                end else begin
                    check("wr_addr", bram_addr, exp_wa.pop_front());
                    check("wr_data", bram_wdata, exp_wd.pop_front());
                end
                last_we_cyc = cyc;
            end
            prev_we = bram_we;
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                rd_cyc.push_back(cyc);
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: data %0h, none expected", m_axis_tdata);
                end else begin
                    check("rd_data", m_axis_tdata, exp_rd.pop_front());
                    check("rd_last", m_axis_tlast, exp_rl.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_early_last"}, early_last, 0);
        check({tag, "_s_tready"}, s_axis_tready, 0);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tdata"}, m_axis_tdata, 0);
        check({tag, "_m_tlast"}, m_axis_tlast, 0);
        check({tag, "_bram_en"}, bram_en, 0);
        check({tag, "_bram_we"}, bram_we, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_wdata"}, bram_wdata, 0);
    endtask

    task automatic do_start(input logic w, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] b);
        @(negedge clk);
        rw = w;
        start_index = s;
        bound_index = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("early_last_cleared", early_last, 0);
    endtask

    task automatic stream_words();
        int g;
        while (sw_data.size() > 0) begin
            g = 0;
            s_axis_tdata  = sw_data.pop_front();
            s_axis_tlast  = sw_last.pop_front();
            s_axis_tvalid = 1'b1;
            while (!s_axis_tready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g == 50) begin
                checks++;
                errors++;
                $display("FAIL stream_stall: tready stuck at 0, required 1");
                sw_data.delete();
                sw_last.delete();
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit toggle, input bit poke_start, output int done_cyc);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (toggle) m_axis_tready = pat[n % 4];
            n++;
        end
        check({name, "_done_seen"}, seen, 1);
        done_cyc = cyc;
        if (seen) begin
            if (poke_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({name, "_done_one_cycle"}, done, 0);
            check({name, "_idle_after_done"}, busy, 0);
        end
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    initial begin
        int dc;
        int tv;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rstn = 1'b1;

        // 1: write two lines 0..1
        push_wr(4'd0, 64'h0004_0003_0002_0001);
        push_wr(4'd1, 64'h0008_0007_0006_0005);
        for (int i = 1; i <= 8; i++) begin
            sw_data.push_back(16'(i));
            sw_last.push_back(1'b0);
        end
        do_start(1'b1, 4'd0, 4'd1);
        stream_words();
        wait_done("t1", 1'b0, 1'b1, dc);
        check("t1_done_after_commit", dc - last_we_cyc, 1);
        check("t1_early_last", early_last, 0);
        check("t1_all_writes", exp_wa.size(), 0);

        // 2: read back with tready held high
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_rd.push_back(16'(i));
            exp_rl.push_back(i == 8);
        end
        rd_cyc.delete();
        do_start(1'b0, 4'd0, 4'd1);
        wait_done("t2", 1'b0, 1'b0, dc);
        check("t2_all_beats", exp_rd.size(), 0);
        check("t2_beat_count", rd_cyc.size(), 8);
        if (rd_cyc.size() == 8) begin
            check("t2_back_to_back", rd_cyc[1] - rd_cyc[0], 1);
            check("t2_line_gap", rd_cyc[4] - rd_cyc[3], 4);
        end

        // 3: read with tready toggling 1,0,0,1
        for (int i = 1; i <= 8; i++) begin
            exp_rd.push_back(16'(i));
            exp_rl.push_back(i == 8);
        end
        do_start(1'b0, 4'd0, 4'd1);
        wait_done("t3", 1'b1, 1'b0, dc);
        check("t3_all_beats", exp_rd.size(), 0);
        m_axis_tready = 1'b1;

        // 4: write wrapping 14 -> 1, tlast on the final word of line N
        push_wr(4'd14, 64'h0014_0013_0012_0011);
        push_wr(4'd15, 64'h0018_0017_0016_0015);
        push_wr(4'd0,  64'h001C_001B_001A_0019);
        push_wr(4'd1,  64'h0020_001F_001E_001D);
        for (int i = 0; i < 16; i++) begin
            sw_data.push_back(16'h0011 + 16'(i));
            sw_last.push_back(i == 15);
        end
        do_start(1'b1, 4'd14, 4'd1);
        stream_words();
        wait_done("t4", 1'b0, 1'b0, dc);
        check("t4_all_writes", exp_wa.size(), 0);
        check("t4_early_last", early_last, 0);

        // 5: early tlast on the 6th word of a 4-line write
        push_wr(4'd0, 64'h0004_0003_0002_0001);
        push_wr(4'd1, 64'h0000_0000_0006_0005);
        for (int i = 1; i <= 6; i++) begin
            sw_data.push_back(16'(i));
            sw_last.push_back(i == 6);
        end
        do_start(1'b1, 4'd0, 4'd3);
        stream_words();
        wait_done("t5", 1'b0, 1'b0, dc);
        check("t5_all_writes", exp_wa.size(), 0);
        check("t5_early_last", early_last, 1);
        check("t5_tready_low", s_axis_tready, 0);

        // 6: reset while stalled in RD_DRAIN, then a clean read
        m_axis_tready = 1'b0;
        do_start(1'b0, 4'd0, 4'd1);
        tv = 0;
        while (!m_axis_tvalid && tv < 20) begin
            @(negedge clk);
            tv++;
        end
        check("t6_tvalid_seen", m_axis_tvalid, 1);
        check("t6_stalled_word", m_axis_tdata, 16'h0001);
        rstn = 1'b0;
        @(negedge clk);
        check_quiet("t6_reset");
        rstn = 1'b1;
        m_axis_tready = 1'b1;
        exp_rd.push_back(16'h0001); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0002); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0003); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0004); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0005); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0006); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0000); exp_rl.push_back(1'b0);
        exp_rd.push_back(16'h0000); exp_rl.push_back(1'b1);
        do_start(1'b0, 4'd0, 4'd1);
        wait_done("t6", 1'b0, 1'b0, dc);
        check("t6_all_beats", exp_rd.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
